// File: rtl/fifo_row_serializer_if.sv
// Handshake bundle between the row FIFO, the serializer and the Q-SPI shifter.
// Widths are derived from the row geometry parameters.
interface fifo_row_serializer_if #(
  parameter int unsigned NUM_TILES = 2,
  parameter int unsigned TILE_W    = 64,
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned ADDR_W    = 8
);
  localparam int unsigned ROW_W = NUM_TILES * TILE_W + ADDR_W;
  localparam int unsigned OUT_W = NUM_TILES * LANE_W;

  logic [ROW_W-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             addr_first;
  logic             shift_en;
  logic             flush;
  logic [OUT_W-1:0] rdata_spi;
  logic             word_valid;
  logic             row_last;
  logic             underrun;
  logic [15:0]      rows_sent;

  // Environment side: FIFO and Q-SPI.
  modport master (
    output fifo_rdata, fifo_empty, addr_first, shift_en, flush,
    input  fifo_rd_en, rdata_spi, word_valid, row_last, underrun, rows_sent
  );

  // Serializer side.
  modport slave (
    input  fifo_rdata, fifo_empty, addr_first, shift_en, flush,
    output fifo_rd_en, rdata_spi, word_valid, row_last, underrun, rows_sent
  );
endinterface

// File: rtl/fifo_row_serializer.sv
// Pops one row (tiles + address) from a sync FIFO and presents it to the Q-SPI as
// one lane per tile, BEATS data beats plus one address beat, address first or last.
module fifo_row_serializer #(
  parameter int unsigned NUM_TILES = 2,
  parameter int unsigned TILE_W    = 64,
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned ADDR_W    = 8
) (
  input logic                    clk,
  input logic                    rst,
  fifo_row_serializer_if.slave   bus
);
  localparam int unsigned ROW_W = NUM_TILES * TILE_W + ADDR_W;
  localparam int unsigned BEATS = TILE_W / LANE_W;
  localparam int unsigned OUT_W = NUM_TILES * LANE_W;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS);

  typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [ROW_W-1:0] row_q;
  logic             mode_q;
  logic [15:0]      rows_q;
  logic             underrun_q, underrun_d;

  logic             rd_en;
  logic             word_valid;
  logic             latch_row;
  logic             row_done;

  logic             is_addr;
  logic [CNT_W-1:0] data_idx;
  int unsigned      shamt;
  logic [TILE_W-1:0] tile;
  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0] word;

  // Next-state, FIFO pop and beat advance.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    rd_en      = 1'b0;
    word_valid = 1'b0;
    latch_row  = 1'b0;
    row_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        rd_en = !bus.fifo_empty && !bus.flush;
        if (rd_en) state_d = StWait;
      end
      StWait: begin
        // Popped data is valid now; a flush here throws the row away.
        latch_row = !bus.flush;
        beat_d    = '0;
        state_d   = bus.flush ? StIdle : StShift;
      end
      StShift: begin
        word_valid = 1'b1;
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.shift_en) begin
          if (beat_q == LastBeat) begin
            row_done = 1'b1;
            if (!bus.fifo_empty) begin
              rd_en   = 1'b1;
              state_d = StWait;
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Keep the pop quiet while reset is held.
    if (rst) rd_en = 1'b0;
  end

  // Sticky underrun; flush clears it and wins over a simultaneous set.
  always_comb begin
    underrun_d = underrun_q | (bus.shift_en & ~word_valid);
    if (bus.flush) underrun_d = 1'b0;
  end

  // State, counters and the latched row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      row_q      <= '0;
      mode_q     <= 1'b0;
      rows_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      underrun_q <= underrun_d;
      if (latch_row) begin
        row_q  <= bus.fifo_rdata;
        mode_q <= bus.addr_first;
      end
      if (row_done) rows_q <= rows_q + 16'd1;
    end
  end

  // Beat map: pick lane k of every tile, or replicate the address into every lane.
  always_comb begin
    is_addr  = mode_q ? (beat_q == '0) : (beat_q == LastBeat);
    data_idx = mode_q ? (beat_q - CNT_W'(1)) : beat_q;
    shamt    = is_addr ? 0 : (BEATS - 1 - int'(data_idx)) * LANE_W;
    word     = '0;
    tile     = '0;
    lane     = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      tile = row_q[ROW_W-1-t*TILE_W -: TILE_W];
      tile = tile >> shamt;
      lane = is_addr ? LANE_W'(row_q[ADDR_W-1:0]) : tile[LANE_W-1:0];
      word[OUT_W-1-t*LANE_W -: LANE_W] = lane;
    end
    if (!word_valid) word = '0;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.word_valid = word_valid;
  assign bus.rdata_spi  = word;
  assign bus.row_last   = word_valid && (beat_q == LastBeat);
  assign bus.underrun   = underrun_q;
  assign bus.rows_sent  = rows_q;
endmodule

// File: tb/tb_fifo_row_serializer.sv
// Directed bench for fifo_row_serializer: default 2x64 geometry with a small FIFO
// model, plus a 4x32 instance driven by hand.
module tb_fifo_row_serializer;
  localparam int unsigned ROW_W  = 136;
  localparam int unsigned ROW7_W = 136;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_row_serializer_if bus ();
  fifo_row_serializer_if #(.NUM_TILES(4), .TILE_W(32), .LANE_W(8), .ADDR_W(8)) b7 ();

  fifo_row_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fifo_row_serializer #(.NUM_TILES(4), .TILE_W(32), .LANE_W(8), .ADDR_W(8)) dut7 (
    .clk (clk),
    .rst (rst),
    .bus (b7.slave)
  );

  int checks = 0;
  int errors = 0;

  // Row FIFO model: data valid the cycle after a pop.
  logic [ROW_W-1:0] fmem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      bus.fifo_rdata <= fmem[rd_ptr % 16];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  localparam logic [ROW_W-1:0] RowA = {64'h0011223344556677, 64'h8899AABBCCDDEEFF, 8'h5A};
  localparam logic [ROW_W-1:0] RowB = {64'hF0E1D2C3B4A59687, 64'h0F1E2D3C4B5A6978, 8'hC3};
  localparam logic [ROW7_W-1:0] Row7 = {32'h01020304, 32'h11121314, 32'h21222324,
                                        32'h31323334, 8'hA5};
  logic [15:0] words1 [9] = '{16'h0088, 16'h1199, 16'h22AA, 16'h33BB, 16'h44CC,
                              16'h55DD, 16'h66EE, 16'h77FF, 16'h5A5A};
  logic [31:0] words7 [5] = '{32'h01112131, 32'h02122232, 32'h03132333, 32'h04142434,
                              32'hA5A5A5A5};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ROW_W-1:0] r);
    fmem[wr_ptr % 16] = r;
    wr_ptr++;
  endtask

  // Expected word for beat i of a 2x64 row, straight from the lane formula.
  function automatic logic [15:0] exp_word(input logic [ROW_W-1:0] r, input bit mode,
                                           input int i);
    int k;
    logic [15:0] w;
    if ((mode && i == 0) || (!mode && i == 8)) return {r[7:0], r[7:0]};
    k = mode ? i - 1 : i;
    w[15:8] = r[135 - 8*k -: 8];
    w[7:0]  = r[71 - 8*k -: 8];
    return w;
  endfunction

  // From IDLE with a row queued: pop, then the WAIT bubble.
  task automatic start_row(input string tag);
    #1;
    chk({tag, "_rd_en"}, 64'(bus.fifo_rd_en), 64'd1);
    cyc();
    #1;
    chk({tag, "_wait_valid"}, 64'(bus.word_valid), 64'd0);
    chk({tag, "_wait_rd_en"}, 64'(bus.fifo_rd_en), 64'd0);
    cyc();
  endtask

  // Shift a whole row with shift_en held high.
  task automatic expect_row(input string tag, input logic [ROW_W-1:0] r, input bit mode,
                            input bit rd_at_last);
    bus.shift_en = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      #1;
      chk({tag, "_valid"}, 64'(bus.word_valid), 64'd1);
      chk({tag, "_word"}, 64'(bus.rdata_spi), 64'(exp_word(r, mode, i)));
      chk({tag, "_last"}, 64'(bus.row_last), 64'(i == 8));
      if (i == 8) chk({tag, "_rd_at_last"}, 64'(bus.fifo_rd_en), 64'(rd_at_last));
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus.addr_first = 1'b0;
    bus.shift_en   = 1'b0;
    bus.flush      = 1'b0;
    b7.fifo_rdata  = '0;
    b7.fifo_empty  = 1'b1;
    b7.addr_first  = 1'b0;
    b7.shift_en    = 1'b0;
    b7.flush       = 1'b0;

    // Reset: outputs low even with a row waiting.
    push(RowA);
    #2;
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(bus.word_valid), 64'd0);
    chk("rst_rdata", 64'(bus.rdata_spi), 64'd0);
    chk("rst_last", 64'(bus.row_last), 64'd0);
    chk("rst_underrun", 64'(bus.underrun), 64'd0);
    chk("rst_rows", 64'(bus.rows_sent), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;

    // 1: address last, literal words.
    start_row("t1");
    bus.shift_en = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      #1;
      chk("t1_valid", 64'(bus.word_valid), 64'd1);
      chk("t1_word", 64'(bus.rdata_spi), 64'(words1[i]));
      chk("t1_last", 64'(bus.row_last), 64'(i == 8));
      cyc();
    end
    bus.shift_en = 1'b0;
    #1;
    chk("t1_idle_valid", 64'(bus.word_valid), 64'd0);
    chk("t1_idle_rdata", 64'(bus.rdata_spi), 64'd0);
    chk("t1_idle_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("t1_rows", 64'(bus.rows_sent), 64'd1);
    chk("t1_underrun", 64'(bus.underrun), 64'd0);

    // 2: address first.
    bus.addr_first = 1'b1;
    push(RowA);
    start_row("t2");
    bus.addr_first = 1'b0;
    expect_row("t2", RowA, 1'b1, 1'b0);
    bus.shift_en = 1'b0;
    #1;
    chk("t2_rows", 64'(bus.rows_sent), 64'd2);

    // 3: back-to-back rows, one gap cycle.
    push(RowA);
    push(RowB);
    start_row("t3");
    expect_row("t3a", RowA, 1'b0, 1'b1);
    #1;
    chk("t3_gap_valid", 64'(bus.word_valid), 64'd0);
    chk("t3_gap_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    cyc();
    expect_row("t3b", RowB, 1'b0, 1'b0);
    bus.shift_en = 1'b0;
    #1;
    chk("t3_rows", 64'(bus.rows_sent), 64'd4);
    chk("t3_underrun", 64'(bus.underrun), 64'd1);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("t3_underrun_clr", 64'(bus.underrun), 64'd0);

    // 4: underrun on an empty FIFO, then cleared by flush.
    bus.shift_en = 1'b1;
    #1;
    chk("t4_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("t4_valid", 64'(bus.word_valid), 64'd0);
    cyc();
    bus.shift_en = 1'b0;
    #1;
    chk("t4_underrun", 64'(bus.underrun), 64'd1);
    chk("t4_rows", 64'(bus.rows_sent), 64'd4);
    bus.flush = 1'b1;
    #1;
    chk("t4_underrun_hold", 64'(bus.underrun), 64'd1);
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("t4_underrun_clr", 64'(bus.underrun), 64'd0);

    // 5: flush at beat 3, then a fresh row from its first word.
    push(RowA);
    start_row("t5");
    bus.shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_word", 64'(bus.rdata_spi), 64'(words1[i]));
      cyc();
    end
    bus.flush = 1'b1;
    #1;
    chk("t5_beat3_word", 64'(bus.rdata_spi), 64'h33BB);
    cyc();
    bus.flush    = 1'b0;
    bus.shift_en = 1'b0;
    #1;
    chk("t5_flush_valid", 64'(bus.word_valid), 64'd0);
    chk("t5_flush_rdata", 64'(bus.rdata_spi), 64'd0);
    chk("t5_flush_rows", 64'(bus.rows_sent), 64'd4);
    push(RowA);
    start_row("t5r");
    expect_row("t5r", RowA, 1'b0, 1'b0);
    bus.shift_en = 1'b0;
    #1;
    chk("t5_rows", 64'(bus.rows_sent), 64'd5);
    // Flush in WAIT drops the popped row.
    push(RowB);
    #1;
    chk("t5w_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    cyc();
    bus.flush = 1'b1;
    #1;
    chk("t5w_rd_en_flush", 64'(bus.fifo_rd_en), 64'd0);
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("t5w_valid", 64'(bus.word_valid), 64'd0);
    chk("t5w_rd_en_after", 64'(bus.fifo_rd_en), 64'd0);
    cyc();
    #1;
    chk("t5w_valid2", 64'(bus.word_valid), 64'd0);
    chk("t5w_rows", 64'(bus.rows_sent), 64'd5);

    // 6: asynchronous reset at beat 5.
    push(RowA);
    start_row("t6");
    bus.shift_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_word", 64'(bus.rdata_spi), 64'(words1[i]));
      cyc();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.word_valid), 64'd0);
    chk("t6_rdata", 64'(bus.rdata_spi), 64'd0);
    chk("t6_last", 64'(bus.row_last), 64'd0);
    chk("t6_rows", 64'(bus.rows_sent), 64'd0);
    chk("t6_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    bus.shift_en = 1'b0;
    cyc();
    rst = 1'b0;
    push(RowB);
    start_row("t6r");
    expect_row("t6r", RowB, 1'b0, 1'b0);
    bus.shift_en = 1'b0;
    #1;
    chk("t6r_rows", 64'(bus.rows_sent), 64'd1);

    // 7: 4 tiles x 32 bits, 32-bit words.
    b7.fifo_empty = 1'b0;
    #1;
    chk("t7_rd_en", 64'(b7.fifo_rd_en), 64'd1);
    cyc();
    b7.fifo_empty = 1'b1;
    b7.fifo_rdata = Row7;
    #1;
    chk("t7_wait_valid", 64'(b7.word_valid), 64'd0);
    cyc();
    b7.shift_en = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      #1;
      chk("t7_valid", 64'(b7.word_valid), 64'd1);
      chk("t7_word", 64'(b7.rdata_spi), 64'(words7[i]));
      chk("t7_last", 64'(b7.row_last), 64'(i == 4));
      cyc();
    end
    b7.shift_en = 1'b0;
    #1;
    chk("t7_idle_valid", 64'(b7.word_valid), 64'd0);
    chk("t7_rows", 64'(b7.rows_sent), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
